// File: rtl/cmv_spi_pkg.sv
// Shared types and constants for the CMV SPI init/host sequencer.
package cmv_spi_pkg;

    typedef enum logic [3:0] {
        ST_QUIET   = 4'd0,
        ST_IDLE    = 4'd1,
        ST_LOAD    = 4'd2,
        ST_ISSUE   = 4'd3,
        ST_WAIT    = 4'd4,
        ST_RELEASE = 4'd5,
        ST_NEXT    = 4'd6,
        ST_DONE    = 4'd7,
        ST_ERROR   = 4'd8
    } seq_state_t;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } rom_entry_t;

    localparam logic CTRL_WRITE = 1'b1;
    localparam logic CTRL_READ  = 1'b0;

    localparam int GAP_DEFAULT     = 4;
    localparam int QUIET_DEFAULT   = 72;
    localparam int TIMEOUT_DEFAULT = 200;

    // Completion flag that belongs to the frame currently on the engine.
    function automatic logic sel_flag(input logic ctrl, input logic wr_done, input logic rd_done);
        return (ctrl == CTRL_WRITE) ? wr_done : rd_done;
    endfunction

endpackage

// File: rtl/cmv_init_rom.sv
// Sensor register init table; entries at or beyond N_REGS read as zero.
module cmv_init_rom
    import cmv_spi_pkg::*;
#(
    parameter int N_REGS = 16
) (
    input  logic [6:0] index,
    output rom_entry_t entry
);

    rom_entry_t table_s;

    // Table lookup by index.
    always_comb begin
        table_s = {7'h00, 8'h00};
        case (index)
            7'd0:    table_s = {7'h39, 8'h08};
            7'd1:    table_s = {7'h44, 8'h02};
            7'd2:    table_s = {7'h66, 8'hAA};
            7'd3:    table_s = {7'h4A, 8'h6E};
            7'd4:    table_s = {7'h52, 8'h01};
            7'd5:    table_s = {7'h59, 8'h40};
            7'd6:    table_s = {7'h5C, 8'h03};
            7'd7:    table_s = {7'h60, 8'h20};
            7'd8:    table_s = {7'h61, 8'h07};
            7'd9:    table_s = {7'h62, 8'h38};
            7'd10:   table_s = {7'h63, 8'h3C};
            7'd11:   table_s = {7'h67, 8'h55};
            7'd12:   table_s = {7'h6A, 8'h0F};
            7'd13:   table_s = {7'h6D, 8'h62};
            7'd14:   table_s = {7'h73, 8'h11};
            7'd15:   table_s = {7'h76, 8'h1D};
            default: table_s = {7'h00, 8'h00};
        endcase
    end

    assign entry = (int'(index) < N_REGS) ? table_s : {7'h00, 8'h00};

endmodule

// File: rtl/cmv_spi_sequencer.sv
// Walks the sensor init table over the SPI bit-engine (optionally verifying
// each write by readback) and serves single host accesses when idle.
module cmv_spi_sequencer
    import cmv_spi_pkg::*;
#(
    parameter int N_REGS       = 16,
    parameter int VERIFY       = 1,
    parameter int GAP_CYCLES   = GAP_DEFAULT,
    parameter int QUIET_CYCLES = QUIET_DEFAULT,
    parameter int TIMEOUT      = TIMEOUT_DEFAULT
) (
    input  logic       FSM_Clk,
    input  logic       reset,
    input  logic       init_start,
    output logic       init_busy,
    output logic       init_done,
    output logic       init_error,
    output logic [6:0] err_index,
    output logic [7:0] err_rdata,
    input  logic       host_req,
    input  logic       host_rw,
    input  logic [6:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic [7:0] host_rdata,
    output logic       host_done,
    output logic       spi_start,
    output logic       spi_control,
    output logic [6:0] spi_address,
    output logic [7:0] spi_wdata,
    input  logic [7:0] spi_rdata,
    input  logic       spi_write_complete,
    input  logic       spi_read_complete
);

    localparam logic [15:0] QUIET_LOAD = 16'(QUIET_CYCLES);
    localparam logic [7:0]  GAP_LOAD   = 8'(GAP_CYCLES - 1);
    localparam logic [7:0]  TO_LAST    = 8'(TIMEOUT - 1);
    localparam logic [6:0]  LAST_INDEX = 7'(N_REGS - 1);

    seq_state_t  state_r, state_s;
    logic [15:0] quiet_cnt_r, quiet_cnt_s;
    logic [7:0]  gap_cnt_r, gap_cnt_s;
    logic [7:0]  to_cnt_r, to_cnt_s;
    logic [6:0]  index_r, index_s;
    logic        host_op_r, host_op_s;
    logic        readback_r, readback_s;
    logic        ctrl_r, ctrl_s;
    logic [6:0]  addr_r, addr_s;
    logic [7:0]  wdata_r, wdata_s;
    logic [7:0]  rdata_r, rdata_s;
    logic        init_busy_r, init_busy_s;
    logic        init_done_r, init_done_s;
    logic        init_error_r, init_error_s;
    logic [6:0]  err_index_r, err_index_s;
    logic [7:0]  err_rdata_r, err_rdata_s;
    logic [7:0]  host_rdata_r, host_rdata_s;
    logic        host_done_r, host_done_s;
    logic        spi_start_r;
    rom_entry_t  rom_entry_s;
    logic        flag_s;
    logic        to_hit_s;

    cmv_init_rom #(.N_REGS(N_REGS)) u_rom (
        .index (index_r),
        .entry (rom_entry_s)
    );

    assign flag_s   = sel_flag(ctrl_r, spi_write_complete, spi_read_complete);
    assign to_hit_s = (to_cnt_r >= TO_LAST);

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_s      = state_r;
        quiet_cnt_s  = quiet_cnt_r;
        gap_cnt_s    = gap_cnt_r;
        to_cnt_s     = to_cnt_r;
        index_s      = index_r;
        host_op_s    = host_op_r;
        readback_s   = readback_r;
        ctrl_s       = ctrl_r;
        addr_s       = addr_r;
        wdata_s      = wdata_r;
        rdata_s      = rdata_r;
        init_busy_s  = init_busy_r;
        init_done_s  = init_done_r;
        init_error_s = init_error_r;
        err_index_s  = err_index_r;
        err_rdata_s  = err_rdata_r;
        host_rdata_s = host_rdata_r;
        host_done_s  = 1'b0;
        case (state_r)
            ST_QUIET: begin
                if (quiet_cnt_r == 16'd0) begin
                    state_s = ST_IDLE;
                end else begin
                    quiet_cnt_s = quiet_cnt_r - 16'd1;
                end
            end
            ST_IDLE: begin
                if (init_start) begin
                    index_s      = 7'd0;
                    host_op_s    = 1'b0;
                    init_busy_s  = 1'b1;
                    init_done_s  = 1'b0;
                    init_error_s = 1'b0;
                    state_s      = ST_LOAD;
                end else if (host_req) begin
                    host_op_s = 1'b1;
                    ctrl_s    = host_rw;
                    addr_s    = host_addr;
                    wdata_s   = host_wdata;
                    rdata_s   = 8'h00;
                    to_cnt_s  = 8'd0;
                    state_s   = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                ctrl_s     = CTRL_WRITE;
                addr_s     = rom_entry_s.addr;
                wdata_s    = rom_entry_s.data;
                rdata_s    = 8'h00;
                readback_s = 1'b0;
                to_cnt_s   = 8'd0;
                state_s    = ST_ISSUE;
            end
            ST_ISSUE, ST_WAIT: begin
                if ((state_r == ST_WAIT) && flag_s) begin
                    if (ctrl_r == CTRL_READ) begin
                        rdata_s = spi_rdata;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    gap_cnt_s = GAP_LOAD;
                    state_s   = ST_RELEASE;
                end else if (to_hit_s) begin
                    // Host accesses still honour the gap before returning 0xFF.
                    if (host_op_r) begin
                        rdata_s   = 8'hFF;
                        gap_cnt_s = GAP_LOAD;
                        state_s   = ST_RELEASE;
                    end else begin
                        rdata_s = 8'h00;
                        state_s = ST_ERROR;
                    end
                end else begin
                    to_cnt_s = to_cnt_r + 8'd1;
                    // Stale flags from the previous frame must drop before waiting.
                    if ((state_r == ST_ISSUE) && !flag_s) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = state_r;
                    end
                end
            end
            ST_RELEASE: begin
                if (gap_cnt_r != 8'd0) begin
                    gap_cnt_s = gap_cnt_r - 8'd1;
                end else if (host_op_r) begin
                    host_done_s  = 1'b1;
                    host_rdata_s = rdata_r;
                    host_op_s    = 1'b0;
                    state_s      = ST_IDLE;
                end else if (readback_r) begin
                    if (rdata_r != wdata_r) begin
                        state_s = ST_ERROR;
                    end else begin
                        state_s = ST_NEXT;
                    end
                end else if (VERIFY != 0) begin
                    ctrl_s     = CTRL_READ;
                    readback_s = 1'b1;
                    to_cnt_s   = 8'd0;
                    state_s    = ST_ISSUE;
                end else begin
                    state_s = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (index_r == LAST_INDEX) begin
                    state_s = ST_DONE;
                end else begin
                    index_s = index_r + 7'd1;
                    state_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                init_done_s = 1'b1;
                init_busy_s = 1'b0;
                state_s     = ST_IDLE;
            end
            ST_ERROR: begin
                init_error_s = 1'b1;
                err_index_s  = index_r;
                err_rdata_s  = rdata_r;
                init_busy_s  = 1'b0;
                state_s      = ST_IDLE;
            end
            default: begin
                quiet_cnt_s = QUIET_LOAD;
                state_s     = ST_QUIET;
            end
        endcase
    end

    // State and output registers; spi_start follows the registered state.
    always_ff @(posedge FSM_Clk) begin
        if (reset) begin
            state_r      <= ST_QUIET;
            quiet_cnt_r  <= QUIET_LOAD;
            gap_cnt_r    <= 8'd0;
            to_cnt_r     <= 8'd0;
            index_r      <= 7'd0;
            host_op_r    <= 1'b0;
            readback_r   <= 1'b0;
            ctrl_r       <= 1'b0;
            addr_r       <= 7'd0;
            wdata_r      <= 8'd0;
            rdata_r      <= 8'd0;
            init_busy_r  <= 1'b0;
            init_done_r  <= 1'b0;
            init_error_r <= 1'b0;
            err_index_r  <= 7'd0;
            err_rdata_r  <= 8'd0;
            host_rdata_r <= 8'd0;
            host_done_r  <= 1'b0;
            spi_start_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            quiet_cnt_r  <= quiet_cnt_s;
            gap_cnt_r    <= gap_cnt_s;
            to_cnt_r     <= to_cnt_s;
            index_r      <= index_s;
            host_op_r    <= host_op_s;
            readback_r   <= readback_s;
            ctrl_r       <= ctrl_s;
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
            rdata_r      <= rdata_s;
            init_busy_r  <= init_busy_s;
            init_done_r  <= init_done_s;
            init_error_r <= init_error_s;
            err_index_r  <= err_index_s;
            err_rdata_r  <= err_rdata_s;
            host_rdata_r <= host_rdata_s;
            host_done_r  <= host_done_s;
            spi_start_r  <= (state_s == ST_ISSUE) || (state_s == ST_WAIT);
        end
    end

    assign init_busy   = init_busy_r;
    assign init_done   = init_done_r;
    assign init_error  = init_error_r;
    assign err_index   = err_index_r;
    assign err_rdata   = err_rdata_r;
    assign host_rdata  = host_rdata_r;
    assign host_done   = host_done_r;
    assign spi_start   = spi_start_r;
    assign spi_control = ctrl_r;
    assign spi_address = addr_r;
    assign spi_wdata   = wdata_r;

endmodule

// File: tb/tb_cmv_spi_sequencer.sv
// Bench: two sequencers (VERIFY=0 and VERIFY=1) each driving its own
// behavioural SPI engine/sensor model; shared stimulus, per-instance checks.
`timescale 1ns/1ps
module tb_cmv_spi_sequencer;

    localparam int N_REGS_P  = 3;
    localparam int GAP_P     = 4;
    localparam int QUIET_P   = 20;
    localparam int TIMEOUT_P = 60;

    logic       clk = 1'b0;
    logic       reset;
    logic       init_start;
    logic       host_req;
    logic       host_rw;
    logic [6:0] host_addr;
    logic [7:0] host_wdata;
    logic       silent;
    logic       corrupt;

    int checks   = 0;
    int failures = 0;

    logic [14:0] tbl [3];
    logic [7:0]  ref_mem [128];

    always #5 clk = ~clk;

    // Power-on register contents of the modelled sensor.
    function automatic logic [7:0] plant_init(input int a);
        return (a == 127) ? 8'h5A : (8'(a) ^ 8'hA5);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        logic       init_busy, init_done, init_error, host_done;
        logic       spi_start, spi_control, wc, rc;
        logic [6:0] err_index, spi_address;
        logic [7:0] err_rdata, host_rdata, spi_wdata, rd;
        logic [7:0] mem [128];
        logic       prev, busy, ctl;
        logic [6:0] adr;
        logic [7:0] wd;
        int         cnt;
        logic [15:0] log_q [$];
        int         low_run = 0, min_gap = 1000, hi_run = 0, last_hi = 0, done_cnt = 0;
        logic       seen_frame = 1'b0;
        logic [7:0] last_host_rdata = 8'h00;

        cmv_spi_sequencer #(
            .N_REGS(N_REGS_P), .VERIFY(g), .GAP_CYCLES(GAP_P),
            .QUIET_CYCLES(QUIET_P), .TIMEOUT(TIMEOUT_P)
        ) dut (
            .FSM_Clk(clk), .reset(reset), .init_start(init_start),
            .init_busy(init_busy), .init_done(init_done), .init_error(init_error),
            .err_index(err_index), .err_rdata(err_rdata),
            .host_req(host_req), .host_rw(host_rw), .host_addr(host_addr),
            .host_wdata(host_wdata), .host_rdata(host_rdata), .host_done(host_done),
            .spi_start(spi_start), .spi_control(spi_control), .spi_address(spi_address),
            .spi_wdata(spi_wdata), .spi_rdata(rd),
            .spi_write_complete(wc), .spi_read_complete(rc)
        );

        // Engine + sensor model: flags clear one cycle after start is sampled,
        // complete after a random latency, and stay set until the next frame.
        always @(posedge clk) begin
            if (reset) begin
                wc   <= 1'b0;
                rc   <= 1'b0;
                busy <= 1'b0;
                prev <= 1'b0;
                cnt  <= 0;
                for (int i = 0; i < 128; i++) mem[i] <= plant_init(i);
            end else begin
                prev <= spi_start;
                if (spi_start && !prev) begin
                    log_q.push_back({spi_control, spi_address, spi_wdata});
                    wc   <= 1'b0;
                    rc   <= 1'b0;
                    busy <= 1'b1;
                    cnt  <= int'($urandom_range(12, 3));
                    ctl  <= spi_control;
                    adr  <= spi_address;
                    wd   <= spi_wdata;
                end else if (busy) begin
                    if (!spi_start) begin
                        busy <= 1'b0;
                    end else if (cnt > 0) begin
                        cnt <= cnt - 1;
                    end else if (!silent) begin
                        busy <= 1'b0;
                        if (ctl) begin
                            mem[adr] <= wd;
                            wc       <= 1'b1;
                        end else begin
                            rd <= (corrupt && adr == 7'h44) ? 8'h03 : mem[adr];
                            rc <= 1'b1;
                        end
                    end
                end
            end
        end

        // Frame timing and host completion monitor.
        always @(posedge clk) begin
            if (host_done) begin
                done_cnt        <= done_cnt + 1;
                last_host_rdata <= host_rdata;
            end
            if (reset) begin
                seen_frame <= 1'b0;
                min_gap    <= 1000;
                low_run    <= 0;
            end else if (spi_start) begin
                if (!prev) begin
                    if (seen_frame && low_run < min_gap) min_gap <= low_run;
                    seen_frame <= 1'b1;
                    hi_run     <= 1;
                end else begin
                    hi_run <= hi_run + 1;
                end
            end else begin
                low_run <= prev ? 1 : low_run + 1;
                if (prev) last_hi <= hi_run;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_init();
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
    endtask

    task automatic wait_walk(input string name);
        int n;
        n = 0;
        while ((u[0].init_busy || u[1].init_busy) && n < 3000) begin
            tick();
            n++;
        end
        check({name, " walk ends"}, 64'(n < 3000), 64'd1);
        tick(2);
    endtask

    // Compare the frames logged since 'base' with the walk the table implies.
    task automatic check_log(input string name, input logic [15:0] q[$], input int base,
                             input int entries, input bit verify);
        int k;
        k = base;
        check({name, " frames"}, 64'(q.size() - base), 64'(verify ? 2 * entries : entries));
        for (int i = 0; i < entries; i++) begin
            if (k < q.size()) check({name, " write frame"}, 64'(q[k]), 64'({1'b1, tbl[i]}));
            k++;
            if (verify) begin
                if (k < q.size()) check({name, " read frame"}, 64'(q[k]), 64'({1'b0, tbl[i]}));
                k++;
            end
        end
    endtask

    task automatic host_op(input string name, input logic rw, input logic [6:0] a,
                           input logic [7:0] d, input logic [7:0] exp);
        int d0, d1, n;
        d0 = u[0].done_cnt;
        d1 = u[1].done_cnt;
        n  = 0;
        host_rw = rw; host_addr = a; host_wdata = d; host_req = 1'b1;
        tick();
        host_req = 1'b0;
        while ((u[0].done_cnt == d0 || u[1].done_cnt == d1) && n < 500) begin
            tick();
            n++;
        end
        tick(3);
        check({name, " done pulses u0"}, 64'(u[0].done_cnt - d0), 64'd1);
        check({name, " done pulses u1"}, 64'(u[1].done_cnt - d1), 64'd1);
        if (!rw) begin
            check({name, " rdata u0"}, 64'(u[0].last_host_rdata), 64'(exp));
            check({name, " rdata u1"}, 64'(u[1].last_host_rdata), 64'(exp));
        end
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } host_vec_t;

    host_vec_t vec [7];

    initial begin
        int b0, b1, n, d0, d1;
        logic       rw;
        logic [6:0] a;
        logic [7:0] d;

        tbl[0] = {7'h39, 8'h08};
        tbl[1] = {7'h44, 8'h02};
        tbl[2] = {7'h66, 8'hAA};
        vec[0] = '{1'b0, 7'h7F, 8'h00, 8'h5A};
        vec[1] = '{1'b1, 7'h10, 8'h33, 8'h00};
        vec[2] = '{1'b0, 7'h10, 8'h00, 8'h33};
        vec[3] = '{1'b1, 7'h7F, 8'hC3, 8'h00};
        vec[4] = '{1'b0, 7'h7F, 8'h00, 8'hC3};
        vec[5] = '{1'b0, 7'h00, 8'h00, 8'hA5};
        vec[6] = '{1'b0, 7'h44, 8'h00, 8'h02};
        for (int i = 0; i < 128; i++) ref_mem[i] = plant_init(i);

        reset = 1'b1; init_start = 1'b0; host_req = 1'b0; host_rw = 1'b0;
        host_addr = 7'd0; host_wdata = 8'd0; silent = 1'b0; corrupt = 1'b0;
        tick(4);
        check("reset outputs u0", {u[0].spi_start, u[0].spi_control, u[0].spi_address,
              u[0].spi_wdata, u[0].init_busy, u[0].init_done, u[0].init_error,
              u[0].err_index, u[0].err_rdata, u[0].host_rdata, u[0].host_done}, 64'd0);
        check("reset outputs u1", {u[1].spi_start, u[1].spi_control, u[1].spi_address,
              u[1].spi_wdata, u[1].init_busy, u[1].init_done, u[1].init_error,
              u[1].err_index, u[1].err_rdata, u[1].host_rdata, u[1].host_done}, 64'd0);
        reset = 1'b0;

        // Requests during the quiet period are dropped, not deferred.
        tick(2);
        init_start = 1'b1; host_req = 1'b1;
        tick();
        init_start = 1'b0; host_req = 1'b0;
        tick(QUIET_P + 6);
        check("quiet no frames", 64'(u[0].log_q.size() + u[1].log_q.size()), 64'd0);
        check("quiet no busy", 64'({u[0].init_busy, u[1].init_busy}), 64'd0);
        check("quiet no host_done", 64'(u[0].done_cnt + u[1].done_cnt), 64'd0);

        // Plain init walk on both instances.
        b0 = u[0].log_q.size(); b1 = u[1].log_q.size();
        pulse_init();
        check("busy after start", 64'({u[0].init_busy, u[1].init_busy}), 64'h3);
        wait_walk("walk1");
        check("walk1 done/err u0", 64'({u[0].init_done, u[0].init_error}), 64'h2);
        check("walk1 done/err u1", 64'({u[1].init_done, u[1].init_error}), 64'h2);
        check_log("walk1 u0", u[0].log_q, b0, 3, 1'b0);
        check_log("walk1 u1", u[1].log_q, b1, 3, 1'b1);
        check("gap u0 >= GAP", 64'(u[0].min_gap >= GAP_P), 64'd1);
        check("gap u1 == GAP", 64'(u[1].min_gap), 64'(GAP_P));
        for (int i = 0; i < 3; i++) ref_mem[tbl[i][14:8]] = tbl[i][7:0];

        // Directed host accesses.
        for (int i = 0; i < 7; i++) begin
            host_op("host vec", vec[i].rw, vec[i].addr, vec[i].wdata, vec[i].exp);
            if (vec[i].rw) ref_mem[vec[i].addr] = vec[i].wdata;
        end

        // Randomised host accesses against the reference register file.
        for (int i = 0; i < 20; i++) begin
            rw = 1'($urandom_range(1, 0));
            a  = 7'h20 + 7'($urandom_range(3, 0));
            d  = 8'($urandom);
            host_op("host rand", rw, a, d, ref_mem[a]);
            if (rw) ref_mem[a] = d;
        end

        // Simultaneous init_start + host_req, and host_req mid-walk: init only.
        d0 = u[0].done_cnt; d1 = u[1].done_cnt;
        b0 = u[0].log_q.size(); b1 = u[1].log_q.size();
        host_rw = 1'b0; host_addr = 7'h7F;
        host_req = 1'b1; init_start = 1'b1;
        tick();
        host_req = 1'b0; init_start = 1'b0;
        tick(30);
        host_req = 1'b1;
        tick();
        host_req = 1'b0;
        wait_walk("walk2");
        tick(10);
        check("walk2 no host_done", 64'((u[0].done_cnt - d0) + (u[1].done_cnt - d1)), 64'd0);
        check("walk2 done u0/u1", 64'({u[0].init_done, u[1].init_done}), 64'h3);
        check_log("walk2 u0", u[0].log_q, b0, 3, 1'b0);
        check_log("walk2 u1", u[1].log_q, b1, 3, 1'b1);

        // Readback of index 1 corrupted: verifying instance stops there.
        corrupt = 1'b1;
        b0 = u[0].log_q.size(); b1 = u[1].log_q.size();
        pulse_init();
        wait_walk("walk3");
        corrupt = 1'b0;
        check("corrupt u1 done/err", 64'({u[1].init_done, u[1].init_error}), 64'h1);
        check("corrupt u1 err_index", 64'(u[1].err_index), 64'd1);
        check("corrupt u1 err_rdata", 64'(u[1].err_rdata), 64'h03);
        check_log("walk3 u1", u[1].log_q, b1, 2, 1'b1);
        check("corrupt u0 done/err", 64'({u[0].init_done, u[0].init_error}), 64'h2);
        check_log("walk3 u0", u[0].log_q, b0, 3, 1'b0);

        // Engine never completes: timeout on the first write.
        silent = 1'b1;
        b0 = u[0].log_q.size(); b1 = u[1].log_q.size();
        pulse_init();
        wait_walk("walk4");
        silent = 1'b0;
        check("timeout u0 done/err", 64'({u[0].init_done, u[0].init_error}), 64'h1);
        check("timeout u1 done/err", 64'({u[1].init_done, u[1].init_error}), 64'h1);
        check("timeout err_index", 64'({u[0].err_index, u[1].err_index}), 64'd0);
        check("timeout err_rdata", 64'({u[0].err_rdata, u[1].err_rdata}), 64'd0);
        check("timeout start low", 64'({u[0].spi_start, u[1].spi_start}), 64'd0);
        check("timeout start width u0", 64'(u[0].last_hi), 64'(TIMEOUT_P));
        check("timeout start width u1", 64'(u[1].last_hi), 64'(TIMEOUT_P));
        check("timeout one frame", 64'((u[0].log_q.size() - b0) + (u[1].log_q.size() - b1)), 64'd2);

        // Reset while waiting on a frame.
        pulse_init();
        n = 0;
        while (!u[1].spi_start && n < 200) begin
            tick();
            n++;
        end
        check("reset test start seen", 64'(n < 200), 64'd1);
        tick(3);
        check("mid-wait start high", 64'(u[1].spi_start), 64'd1);
        reset = 1'b1;
        tick();
        check("reset start drops", 64'({u[0].spi_start, u[1].spi_start}), 64'd0);
        check("reset clears u1", {u[1].spi_control, u[1].spi_address, u[1].spi_wdata,
              u[1].init_busy, u[1].init_done, u[1].init_error, u[1].err_index,
              u[1].err_rdata, u[1].host_rdata, u[1].host_done}, 64'd0);
        tick();
        reset = 1'b0;
        b0 = u[0].log_q.size(); b1 = u[1].log_q.size();
        pulse_init();
        tick(QUIET_P);
        check("post-reset quiet", 64'((u[0].log_q.size() - b0) + (u[1].log_q.size() - b1)), 64'd0);
        tick(5);
        pulse_init();
        wait_walk("walk5");
        check("walk5 done u0/u1", 64'({u[0].init_done, u[1].init_done}), 64'h3);
        check_log("walk5 u1", u[1].log_q, b1, 3, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmv_spi_sequencer.md
Name: cmv_spi_sequencer

Overview:
Upstream controller for the CMV sensor SPI bit-engine. It walks a register-init table and issues one write per entry to the engine, optionally reading each register back to verify it. When idle it also serves single host register reads and writes. It drives the engine's start/control/address/write_data inputs and consumes its write_complete/read_complete/read_data outputs.

Parameters:
N_REGS, 16, number of init-table entries (1..128).
VERIFY, 1, 1 = read back each entry after writing it and compare.
GAP_CYCLES, 4, number of cycles spi_start is held low between transactions (min 2).
QUIET_CYCLES, 72, idle cycles after reset before any transaction; covers an engine caught mid-frame.
TIMEOUT, 200, maximum cycles from spi_start rise to complete flag before an error is raised.

Ports:
FSM_Clk  in  1  FSM clock, shared with the SPI engine.
reset  in  1  synchronous, active-high reset.
init_start  in  1  one-cycle pulse; starts the init table walk.
init_busy  out  1  high while the walk is in progress.
init_done  out  1  sticky; set when the walk finishes clean; cleared by init_start or reset.
init_error  out  1  sticky; set on verify mismatch or timeout; cleared by init_start or reset.
err_index  out  7  table index of the failing entry.
err_rdata  out  8  read-back value for the failing entry (0x00 on timeout).
host_req  in  1  one-cycle pulse; single host access.
host_rw  in  1  1 = write, 0 = read (same coding as the engine control bit).
host_addr  in  7  register address for the host access.
host_wdata  in  8  write data for the host access.
host_rdata  out  8  read result; valid when host_done is high.
host_done  out  1  one-cycle pulse when the host access completes.
spi_start  out  1  to engine start_bit.
spi_control  out  1  to engine control_bit.
spi_address  out  7  to engine address.
spi_wdata  out  8  to engine write_data.
spi_rdata  in  8  from engine read_data.
spi_write_complete  in  1  from engine write_complete.
spi_read_complete  in  1  from engine read_complete.

Behaviour:
- Reset values: all outputs 0; state QUIET; quiet counter loaded with QUIET_CYCLES.
- QUIET: count down with spi_start=0, then go to IDLE. init_start and host_req are ignored in this state.
- IDLE:
  - init_start -> index=0, go to LOAD.
  - Otherwise host_req -> latch host_rw/host_addr/host_wdata, go to ISSUE.
  - If both arrive in the same cycle, init wins and host_req is dropped.
  - host_req during the init walk is ignored; the host must retry after init_busy falls.
- LOAD: fetch {addr, data} from the ROM at index (combinational); drive spi_control=1, spi_address, spi_wdata; go to ISSUE.
- Address/data/control stay stable from ISSUE entry until RELEASE ends.
- ISSUE: spi_start=1; wait until the selected complete flag is 0.
  - The engine clears its flags one cycle after sampling start; stale flags from the previous frame are ignored this way.
  - Then go to WAIT.
- WAIT: spi_start=1; wait for the selected flag to be 1.
  - Flag select: write_complete when control=1, read_complete when control=0.
  - On the flag: capture spi_rdata if reading, go to RELEASE.
- RELEASE: spi_start=0 for GAP_CYCLES, then go to the next state:
  - host access: pulse host_done, then IDLE.
  - init write with VERIFY=1: set control=0, go to ISSUE (readback).
  - init readback: if rdata != data -> ERROR; otherwise go to NEXT.
  - init write with VERIFY=0: go to NEXT.
- NEXT: if index == N_REGS-1, go to DONE; otherwise index+1, go to LOAD.
- DONE: set init_done, clear init_busy, go to IDLE.
- ERROR: set init_error, load err_index/err_rdata, clear init_busy, spi_start=0, go to IDLE. The walk is not resumed.
- Timeout: one 8-bit counter runs in ISSUE+WAIT. Reaching TIMEOUT:
  - drop spi_start and go to ERROR with err_rdata=0;
  - for a host access, instead pulse host_done with host_rdata=0xFF.
- Latency: one write costs ISSUE..RELEASE, about 66+GAP_CYCLES cycles; verify doubles that.
- Reset mid-transaction: spi_start falls at the next edge. QUIET_CYCLES lets the engine finish its frame and return to its init state.

Decomposition:
- Package cmv_spi_pkg: state enum; table entry type {addr[6:0], data[7:0]}; CTRL_WRITE=1, CTRL_READ=0; default GAP/QUIET/TIMEOUT constants.
- Sub-module cmv_init_rom: combinational index -> entry lookup holding the sensor init table; entries beyond N_REGS return 0.

Test Plan:
- Engine model, N_REGS=3, VERIFY=0, table {(0x39,0x08),(0x44,0x02),(0x66,0xAA)} -> three writes in order, init_done=1, init_error=0, spi_start low ≥GAP_CYCLES between frames.
- VERIFY=1, model echoes the written data -> write/read alternate (control 1,0,1,0,...); init_done=1.
- VERIFY=1, model corrupts the read of index 1 (returns 0x03) -> init_error=1, err_index=1, err_rdata=0x03, no write issued for index 2.
- Host read of addr 0x7F while IDLE, model returns 0x5A -> host_done one cycle, host_rdata=0x5A; a simultaneous init_start+host_req -> init runs, no host_done.
- Model never raises complete -> after TIMEOUT cycles spi_start=0, init_error=1, err_rdata=0x00.
- Reset asserted mid-WAIT -> spi_start=0 next edge, outputs cleared, no transaction for QUIET_CYCLES, a later init_start succeeds.
